ora: RTL
========

# ora

Output response analyzer for the LBIST chain. It sits directly downstream of the circuit under test, which the test pattern generator drives. It compacts one CUT response word per clock into a multiple-input signature register (MISR) over a fixed number of patterns. It then compares the final signature against a golden value and reports pass or fail.

## Interface
- `IN_BITS`, default 4: width of the CUT response and of the signature.
- `PATTERNS`, default 16: number of response words compacted per run (≥1).
- `DISCARD`, default 1: cycles ignored after start, covering the pipeline fill (TPG register plus CUT). May be 0.
- `TAPS`, default 4'b0010: MISR feedback taps, `IN_BITS` wide. Bit i=1 XORs the feedback into stage i (i≥1). Bit 0 is ignored, because stage 0 always takes the feedback.
- `GOLDEN`, default 0: expected final signature, `IN_BITS` wide.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: begin a run. Sampled only in IDLE and DONE.
- `RESPONSE`, input, `IN_BITS`: CUT output word.
- `BUSY`, output, 1: a run is in progress (FILL or COMPACT).
- `DONE`, output, 1: the run has finished and `PASS`/`SIGNATURE` are valid. It holds until the next start.
- `PASS`, output, 1: `SIGNATURE == GOLDEN`. Valid only while DONE=1; 0 otherwise.
- `SIGNATURE`, output, `IN_BITS`: current MISR contents, registered.

## Operation
- The state machine has four states: IDLE, FILL, COMPACT, DONE. All outputs are registered.
- **Reset** (`rst`=0, asynchronous): state goes to IDLE. `SIGNATURE`, the counter, `BUSY`, `DONE` and `PASS` all go to 0. Reset asserted mid-run aborts the run immediately, with no partial result.
- **IDLE or DONE, `start`=1:**
  - `SIGNATURE` clears to 0, the counter clears to 0, `DONE` and `PASS` clear to 0, and `BUSY` goes to 1.
  - The next state is FILL if `DISCARD`>0, otherwise COMPACT.
- **FILL:** `RESPONSE` is ignored and the counter increments each cycle. When `DISCARD` cycles have completed, the counter clears and the state goes to COMPACT.
- **COMPACT:** on each edge, one word is absorbed, with fb = `SIGNATURE[IN_BITS-1]`:
  - next[0] = fb ^ `RESPONSE[0]`.
  - next[i] = `SIGNATURE[i-1]` ^ `RESPONSE[i]` ^ (`TAPS[i]` & fb), for i ≥ 1.
  - The counter increments. On the edge that absorbs word number `PATTERNS`, the state goes to DONE, `BUSY`=0, `DONE`=1 and `PASS`=(next signature == `GOLDEN`).
- **DONE:** `SIGNATURE` and `PASS` are frozen. The block stays in DONE until `start`.
- `start` is ignored while `BUSY`=1 (FILL or COMPACT).
- The counter width is clog2(max(`PATTERNS`,`DISCARD`)+1). It never wraps within a run.

## Timing
- `start` high at edge N: `BUSY`=1 after edge N.
- `RESPONSE` values sampled at edges N+1 … N+`DISCARD` are discarded. Edges N+`DISCARD`+1 … N+`DISCARD`+`PATTERNS` are absorbed.
- After edge N+`DISCARD`+`PATTERNS`: `DONE`=1, `BUSY`=0, and `PASS` is valid in the same cycle. The run latency is therefore `DISCARD`+`PATTERNS` cycles after the start edge.
- `BUSY` and `DONE` are never both 1.
- A restart from DONE clears `DONE` on the start edge itself.
- `SIGNATURE` updates only on absorbing edges and on the start-edge clear.

## Test plan
- **Reset mid-run:** assert `rst`=0 during COMPACT → all outputs 0 asynchronously, before the next edge. Release and `start` → a normal run completes.
- **Single-one impulse** (`IN_BITS`=4, `TAPS`=4'b0010, `DISCARD`=0, `PATTERNS`=5, `GOLDEN`=4'b0011): `RESPONSE` = 0001, 0000, 0000, 0000, 0000.
  - `SIGNATURE` steps 0001, 0010, 0100, 1000, 0011.
  - `DONE`=1 and `PASS`=1 five cycles after the start edge.
- **Discard window** (same configuration with `DISCARD`=1): the first response is 1111, followed by the five words above → 1111 is ignored and the final `SIGNATURE`=0011, `PASS`=1.
- **Mismatch:** same as the single-one impulse but with the third word 0100 instead of 0000 → final `SIGNATURE`≠0011 and `PASS`=0 with `DONE`=1.
- **All-zero responses,** default parameters, `GOLDEN`=0 → `SIGNATURE`=0000 throughout and `PASS`=1 after 17 cycles.
- **Start handling:**
  - Pulse `start` during COMPACT → ignored; the run end time is unchanged.
  - `start` while in DONE → `DONE` drops on that edge, `SIGNATURE` clears to 0, and a fresh run completes with an identical signature for identical stimulus.

Source files
------------

// File: rtl/ora.sv
`default_nettype none
// ============================================================================
//  Module   : ora
//  Purpose  : LBIST output response analyzer. Compacts CUT response words
//             into a MISR and compares the final signature to a golden value.
//  Revision : 1.0  initial release
// ============================================================================
module ora #(
    parameter int                 IN_BITS  = 4,
    parameter int                 PATTERNS = 16,
    parameter int                 DISCARD  = 1,
    parameter logic [IN_BITS-1:0] TAPS     = 4'b0010,
    parameter logic [IN_BITS-1:0] GOLDEN   = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IN_BITS-1:0] RESPONSE,
    output logic               BUSY,
    output logic               DONE,
    output logic               PASS,
    output logic [IN_BITS-1:0] SIGNATURE
);

    localparam int c_CNT_MAX   = (PATTERNS > DISCARD) ? PATTERNS : DISCARD;
    localparam int c_CW        = $clog2(c_CNT_MAX + 1);
    localparam int c_FILL_LAST = (DISCARD > 0) ? DISCARD - 1 : 0;
    localparam int c_PAT_LAST  = PATTERNS - 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_COMPACT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CW-1:0]    r_cnt;
    logic [IN_BITS-1:0] r_sig;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [IN_BITS-1:0] w_next;
    logic               w_fb;

    assign w_fb = r_sig[IN_BITS-1];

    // Stage 0 always takes the feedback, so TAPS[0] is never consulted.
    always_comb begin
        w_next    = '0;
        w_next[0] = w_fb ^ RESPONSE[0];
        for (int i = 1; i < IN_BITS; i++) begin
            w_next[i] = r_sig[i-1] ^ RESPONSE[i] ^ (TAPS[i] & w_fb);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sig   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_sig   <= '0;
                        r_cnt   <= '0;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= (DISCARD > 0) ? S_FILL : S_COMPACT;
                    end
                end
                S_FILL: begin
                    if (r_cnt == c_CW'(c_FILL_LAST)) begin
                        r_cnt   <= '0;
                        r_state <= S_COMPACT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_COMPACT: begin
                    r_sig <= w_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CW'(c_PAT_LAST)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_next == GOLDEN);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign PASS      = r_pass;
    assign SIGNATURE = r_sig;

endmodule
`default_nettype wire
